// File: rtl/fpga_scan_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : fpga_scan_loader_if
// Description : Word stream bus into the configuration scan loader. One bit
//               per scan chain per word, valid/ready handshake.
//               s_data  : bit i feeds chain i
//               s_valid : s_data valid (driven by the source)
//               s_ready : loader accepts a word this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface fpga_scan_loader_if #(
    parameter int NUM_CHAINS = 2
);
    logic [NUM_CHAINS-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/fpga_scan_loader.sv
`default_nettype none
// ============================================================================
// Module      : fpga_scan_loader
// Description : Streams a configuration bitstream into NUM_CHAINS parallel
//               scan chains (LOAD) or recirculates the chains while comparing
//               their contents against the stream (VERIFY).
// Ports       : scan_clk/reset      - clock, synchronous active-high reset
//               start/mode/chain_mask - operation request, sampled in IDLE
//               abort               - terminate running operation
//               s_bus (slave)       - word stream, one bit per chain
//               chain_scan_in/en/out - fabric scan pins
//               busy/done/err       - status, done is a one-cycle pulse
//               mismatch_cnt        - VERIFY words with any masked mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_scan_loader #(
    parameter int NUM_CHAINS = 2,
    parameter int CHAIN_LEN  = 1024,
    parameter int MISMATCH_W = 16
) (
    input  logic                  scan_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [NUM_CHAINS-1:0] chain_mask,
    input  logic                  abort,
    fpga_scan_loader_if.slave     s_bus,
    output logic [NUM_CHAINS-1:0] chain_scan_in,
    output logic [NUM_CHAINS-1:0] chain_scan_en,
    input  logic [NUM_CHAINS-1:0] chain_scan_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [MISMATCH_W-1:0] mismatch_cnt
);

    localparam int                 c_CNT_W   = $clog2(CHAIN_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_M1 = c_CNT_W'(CHAIN_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic                  r_mode;
    logic [NUM_CHAINS-1:0] r_mask;
    logic [NUM_CHAINS-1:0] r_exp;
    logic [NUM_CHAINS-1:0] r_scan_en;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic                  r_done;
    logic                  r_err;
    logic [MISMATCH_W-1:0] r_mismatch_cnt;

    logic [1:0] w_state_nxt;
    logic       w_start_ok;
    logic       w_start_bad;
    logic       w_hs;
    logic       w_abort;
    logic       w_finish;
    logic       w_cmp_hit;

    // Next-state and event decode. Abort has priority over a handshake in
    // the same cycle, so an aborted last word never produces done.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        w_hs        = 1'b0;
        w_abort     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    if (|chain_mask) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = c_ST_SHIFT;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end
            c_ST_SHIFT: begin
                if (abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (s_bus.s_valid) begin
                    w_hs = 1'b1;
                    if (r_bit_cnt == c_LAST_M1) begin
                        w_state_nxt = c_ST_DRAIN;
                    end
                end
            end
            c_ST_DRAIN: begin
                w_state_nxt = c_ST_IDLE;
                if (abort) begin
                    w_abort = 1'b1;
                end else begin
                    w_finish = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // The chains shift at every edge where r_scan_en is set; in VERIFY the bit
    // leaving the chain at that edge must equal the word latched for it.
    assign w_cmp_hit = r_mode && (|r_scan_en) &&
                       (|((chain_scan_out ^ r_exp) & r_mask));

    always_ff @(posedge scan_clk) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_mode         <= 1'b0;
            r_mask         <= '0;
            r_exp          <= '0;
            r_scan_en      <= '0;
            r_bit_cnt      <= '0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_mismatch_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_finish | w_start_bad;
            r_scan_en <= w_hs ? r_mask : '0;
            if (w_hs) begin
                r_exp     <= s_bus.s_data;
                r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
            end
            if (w_start_ok) begin
                r_mode         <= mode;
                r_mask         <= chain_mask;
                r_bit_cnt      <= '0;
                r_err          <= 1'b0;
                r_mismatch_cnt <= '0;
            end else begin
                if (w_start_bad || w_abort) begin
                    r_err <= 1'b1;
                end
                if (w_cmp_hit) begin
                    r_err <= 1'b1;
                    if (r_mismatch_cnt != {MISMATCH_W{1'b1}}) begin
                        r_mismatch_cnt <= r_mismatch_cnt + MISMATCH_W'(1);
                    end
                end
            end
        end
    end

    // VERIFY feeds each chain its own output so the configuration comes back
    // unchanged after CHAIN_LEN shifts.
    for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_chain
        assign chain_scan_in[i] = r_mode ? chain_scan_out[i] : r_exp[i];
    end

    assign chain_scan_en = r_scan_en;
    assign s_bus.s_ready = (r_state == c_ST_SHIFT);
    assign busy          = (r_state != c_ST_IDLE);
    assign done          = r_done;
    assign err           = r_err;
    assign mismatch_cnt  = r_mismatch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpga_scan_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpga_scan_loader
// Description : Self-checking bench for fpga_scan_loader with a behavioural
//               fabric of shift-register chains and a stream-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_scan_loader;

    localparam int NC = 2;
    localparam int CL = 8;
    localparam int MW = 16;

    logic          scan_clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic [NC-1:0] chain_mask;
    logic          abort;
    logic [NC-1:0] chain_scan_in;
    logic [NC-1:0] chain_scan_en;
    logic [NC-1:0] chain_scan_out;
    logic          busy;
    logic          done;
    logic          err;
    logic [MW-1:0] mismatch_cnt;

    fpga_scan_loader_if #(.NUM_CHAINS(NC)) bus ();

    fpga_scan_loader #(
        .NUM_CHAINS (NC),
        .CHAIN_LEN  (CL),
        .MISMATCH_W (MW)
    ) dut (
        .scan_clk       (scan_clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .chain_mask     (chain_mask),
        .abort          (abort),
        .s_bus          (bus),
        .chain_scan_in  (chain_scan_in),
        .chain_scan_en  (chain_scan_en),
        .chain_scan_out (chain_scan_out),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mismatch_cnt   (mismatch_cnt)
    );

    initial scan_clk = 1'b0;
    always #5 scan_clk = ~scan_clk;

    // Fabric: each chain shifts towards the MSB; scan_out is the MSB.
    logic [CL-1:0] fab [NC] = '{default: '0};
    always @(posedge scan_clk) begin
        for (int i = 0; i < NC; i++)
            if (chain_scan_en[i]) fab[i] <= {fab[i][CL-2:0], chain_scan_in[i]};
    end
    always_comb begin
        chain_scan_out = '0;
        for (int i = 0; i < NC; i++) chain_scan_out[i] = fab[i][CL-1];
    end

    int n_vec = 0;
    int n_err = 0;

    logic [NC-1:0] words [CL];
    logic [CL-1:0] pre   [NC];
    logic [CL-1:0] mdl   [NC];
    int            mdl_mism;
    int            en_cnt [NC];
    bit            done_seen;
    int            done_cyc;
    bit            busy1;
    bit            reset_hit;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_s_ready", int'(bus.s_ready), 0);
        check("rst_scan_en", int'(chain_scan_en), 0);
        check("rst_scan_in", int'(chain_scan_in), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_mismatch", int'(mismatch_cnt), 0);
    endtask

    // Stream-level reference: word k is the k-th bit into / out of a chain.
    task automatic model_op(input logic m, input logic [NC-1:0] mk);
        mdl_mism = 0;
        for (int i = 0; i < NC; i++) pre[i] = fab[i];
        for (int k = 0; k < CL; k++) begin
            bit diff = 0;
            for (int i = 0; i < NC; i++)
                if (mk[i] && (words[k][i] != pre[i][CL-1-k])) diff = 1;
            if (diff) mdl_mism++;
        end
        for (int i = 0; i < NC; i++) begin
            mdl[i] = pre[i];
            if (!m && mk[i])
                for (int k = 0; k < CL; k++) mdl[i][CL-1-k] = words[k][i];
        end
    endtask

    task automatic fill_alt(input logic [NC-1:0] first, input int flip_w, input logic [NC-1:0] flip_b);
        for (int k = 0; k < CL; k++) words[k] = (k % 2 == 0) ? first : ~first;
        if (flip_w >= 0) words[flip_w] = words[flip_w] ^ flip_b;
    endtask

    // Runs one operation; called and returns #1 after a rising edge.
    task automatic do_op(input logic m, input logic [NC-1:0] mk, input bit gaps,
                         input int abort_at, input int restart_at, input int reset_at);
        int k = 0;
        int cyc;
        bit fin = 0;
        bit aborted = 0;
        bit hs;
        done_seen = 0; done_cyc = -1; reset_hit = 0; busy1 = 0;
        for (int i = 0; i < NC; i++) en_cnt[i] = 0;
        start = 1'b1; mode = m; chain_mask = mk;
        @(posedge scan_clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 200) begin
            for (int i = 0; i < NC; i++) if (chain_scan_en[i]) en_cnt[i]++;
            if (cyc == 1) busy1 = busy;
            if (done) begin
                done_seen = 1; done_cyc = cyc; fin = 1;
            end else if (!busy) begin
                fin = 1;
            end else begin
                bus.s_valid = (k < CL) && (!gaps || $urandom_range(0, 2) != 0);
                bus.s_data  = (k < CL) ? words[k] : '0;
                abort = (abort_at >= 0) && (k == abort_at) && !aborted;
                if (abort) aborted = 1;
                reset = (reset_at >= 0) && (k == reset_at);
                if (cyc == restart_at) begin
                    start = 1'b1; mode = 1'b1; chain_mask = 2'b01;
                end
                hs = bus.s_valid && bus.s_ready;
                @(posedge scan_clk); #1;
                if (hs) k++;
                start = 1'b0; mode = m; chain_mask = mk;
                abort = 1'b0; bus.s_valid = 1'b0;
                if (reset) begin
                    reset = 1'b0; reset_hit = 1; fin = 1;
                end
                cyc++;
            end
        end
        check("op_bounded", int'(fin), 1);
    endtask

    task automatic check_op(input logic m, input logic [NC-1:0] mk, input bit gaps, input int restart_at,
                            input int exp_done_cyc, input logic exp_err, input int exp_mism);
        model_op(m, mk);
        do_op(m, mk, gaps, -1, restart_at, -1);
        check("busy_after_start", int'(busy1), 1);
        check("done_seen", int'(done_seen), 1);
        if (exp_done_cyc > 0) check("done_cycle", done_cyc, exp_done_cyc);
        check("err", int'(err), int'(exp_err));
        check("mismatch_cnt", int'(mismatch_cnt), exp_mism);
        for (int i = 0; i < NC; i++) begin
            check($sformatf("chain%0d_content", i), int'(fab[i]), int'(mdl[i]));
            check($sformatf("chain%0d_en_cycles", i), en_cnt[i], mk[i] ? CL : 0);
        end
        @(posedge scan_clk); #1;
        check("done_single_pulse", int'(done), 0);
    endtask

    typedef struct {
        logic          mode;
        logic [NC-1:0] mask;
        logic [NC-1:0] first;
        int            flip_w;
        logic [NC-1:0] flip_b;
        bit            gaps;
        int            exp_done_cyc;
        logic          exp_err;
        int            exp_mism;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{1'b0, 2'b11, 2'b01, -1, 2'b00, 1'b0, 10, 1'b0, 0};
        vt[1] = '{1'b1, 2'b11, 2'b01, -1, 2'b00, 1'b0, 10, 1'b0, 0};
        vt[2] = '{1'b1, 2'b11, 2'b01,  3, 2'b10, 1'b0, 10, 1'b1, 1};
        vt[3] = '{1'b0, 2'b10, 2'b01, -1, 2'b00, 1'b1, -1, 1'b0, 0};
        vt[4] = '{1'b1, 2'b11, 2'b01, -1, 2'b00, 1'b1, -1, 1'b0, 0};
        vt[5] = '{1'b1, 2'b01, 2'b01,  0, 2'b11, 1'b0, 10, 1'b1, 1};
        vt[6] = '{1'b0, 2'b01, 2'b00, -1, 2'b00, 1'b0, 10, 1'b0, 0};
        vt[7] = '{1'b1, 2'b11, 2'b10, -1, 2'b00, 1'b0, 10, 1'b1, 8};

        reset = 1'b1; start = 1'b0; mode = 1'b0; chain_mask = '0; abort = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (3) @(posedge scan_clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge scan_clk); #1;

        for (int v = 0; v < 8; v++) begin
            fill_alt(vt[v].first, vt[v].flip_w, vt[v].flip_b);
            check_op(vt[v].mode, vt[v].mask, vt[v].gaps, -1,
                     vt[v].exp_done_cyc, vt[v].exp_err, vt[v].exp_mism);
        end

        // start while busy is ignored; LOAD of both chains completes normally
        fill_alt(2'b01, -1, 2'b00);
        check_op(1'b0, 2'b11, 1'b0, 3, 10, 1'b0, 0);

        // abort after 4 words
        do_op(1'b0, 2'b11, 1'b0, 4, -1, -1);
        check("abort_no_done", int'(done_seen), 0);
        check("abort_err", int'(err), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_en_cycles", en_cnt[0], 4);

        // abort together with the last handshake
        do_op(1'b0, 2'b11, 1'b0, CL - 1, -1, -1);
        check("abort_last_no_done", int'(done_seen), 0);
        check("abort_last_err", int'(err), 1);
        check("abort_last_en_cycles", en_cnt[1], CL - 1);

        // reset in the middle of a LOAD
        do_op(1'b0, 2'b11, 1'b0, -1, -1, 5);
        check("reset_hit", int'(reset_hit), 1);
        check_reset_vals();
        @(posedge scan_clk); #1;
        check("reset_busy_next", int'(busy), 0);

        // empty mask
        do_op(1'b0, 2'b00, 1'b0, -1, -1, -1);
        check("mask0_done_cycle", done_cyc, 1);
        check("mask0_busy", int'(busy1), 0);
        check("mask0_err", int'(err), 1);
        @(posedge scan_clk); #1;
        check("mask0_done_pulse", int'(done), 0);

        // randomized operations against the stream model
        for (int r = 0; r < 10; r++) begin
            logic          m  = 1'($urandom_range(0, 1));
            logic [NC-1:0] mk = NC'($urandom_range(1, 3));
            bit            g  = 1'($urandom_range(0, 1));
            if (m && $urandom_range(0, 1) == 1) begin
                for (int k = 0; k < CL; k++)
                    for (int i = 0; i < NC; i++) words[k][i] = fab[i][CL-1-k];
                if ($urandom_range(0, 1) == 1) begin
                    int fw = $urandom_range(0, CL - 1);
                    words[fw] = words[fw] ^ NC'($urandom_range(1, 3));
                end
            end else begin
                for (int k = 0; k < CL; k++) words[k] = NC'($urandom_range(0, 3));
            end
            model_op(m, mk);
            check_op(m, mk, g, -1, g ? -1 : 10, (m && mdl_mism > 0), m ? mdl_mism : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
